// File: rtl/decode_pkg.sv
// Opcode/funct constants, control-word field layout and encodings shared by the decoder and ID/EX control stage.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam int CTRL_W       = 22;
  localparam int PCSRC_LSB    = 20;
  localparam int BRANCH_BIT   = 19;
  localparam int BRTYPE_LSB   = 16;
  localparam int REGWRITE_BIT = 15;
  localparam int REGDST_LSB   = 13;
  localparam int MEMREAD_BIT  = 12;
  localparam int MEMWRITE_BIT = 11;
  localparam int MEMTOREG_LSB = 9;
  localparam int ALUSRC1_BIT  = 8;
  localparam int ALUSRC2_BIT  = 7;
  localparam int EXTOP_BIT    = 6;
  localparam int LUOP_BIT     = 5;
  localparam int ALUOP_LSB    = 1;
  localparam int MULDIV_BIT   = 0;

  localparam logic [2:0] BR_BEQ    = 3'b000;
  localparam logic [2:0] BR_BNE    = 3'b001;
  localparam logic [2:0] BR_BLEZ   = 3'b010;
  localparam logic [2:0] BR_BGTZ   = 3'b011;
  localparam logic [2:0] BR_REGIMM = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_BEQ = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;

  typedef struct packed {
    logic [1:0] pc_src;
    logic       branch;
    logic [2:0] branch_type;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       alu_src1;
    logic       alu_src2;
    logic       ext_op;
    logic       lu_op;
    logic [3:0] alu_op;
    logic       mul_div;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS main decoder: instruction -> control word, illegal flag and register-read usage.
// Zero latency; no flow control.
module ctrl_decode
  import decode_pkg::*;
#(
  parameter bit ENABLE_EXT = 1'b1
) (
  input  logic [31:0] i_inst,
  output ctrl_t       o_ctrl,
  output logic        o_illegal,
  output logic        o_reads_rs,
  output logic        o_reads_rt
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rt_fld;
  logic       w_unused;
  ctrl_t      w_c;
  logic       w_legal;
  logic       w_rs_rd;
  logic       w_rt_rd;
  logic [2:0] w_alu_lo;

  assign w_op     = i_inst[31:26];
  assign w_fn     = i_inst[5:0];
  assign w_rt_fld = i_inst[20:16];
  assign w_unused = ^{i_inst[25:21], i_inst[15:6]};

  always_comb begin
    w_c     = '0;
    w_legal = 1'b1;
    w_rs_rd = 1'b0;
    w_rt_rd = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_c.reg_dst   = 2'b01;
        w_c.reg_write = 1'b1;
        w_rs_rd       = 1'b1;
        w_rt_rd       = 1'b1;
        case (w_fn)
          FN_SLL, FN_SRL, FN_SRA: begin
            w_c.alu_src1 = 1'b1;
            w_rs_rd      = 1'b0;
          end
          FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: ;
          FN_JR: begin
            w_c.pc_src    = 2'b11;
            w_c.reg_write = 1'b0;
            w_rt_rd       = 1'b0;
          end
          FN_JALR: begin
            w_c.pc_src     = 2'b11;
            w_c.mem_to_reg = 2'b11;
            w_rt_rd        = 1'b0;
          end
          FN_MFHI, FN_MFLO: begin
            w_legal = ENABLE_EXT;
            w_rs_rd = 1'b0;
            w_rt_rd = 1'b0;
          end
          // HI/LO writers leave the GPR file alone
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            w_legal       = ENABLE_EXT;
            w_c.reg_write = 1'b0;
            w_c.mul_div   = 1'b1;
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        w_c.branch      = 1'b1;
        w_c.branch_type = BR_REGIMM;
        w_rs_rd         = 1'b1;
        w_legal         = ENABLE_EXT && (w_rt_fld == 5'd0 || w_rt_fld == 5'd1);
      end
      OP_J: w_c.pc_src = 2'b01;
      OP_JAL: begin
        w_c.pc_src     = 2'b01;
        w_c.reg_write  = 1'b1;
        w_c.reg_dst    = 2'b11;
        w_c.mem_to_reg = 2'b11;
      end
      OP_BEQ, OP_BNE: begin
        w_c.branch      = 1'b1;
        w_c.branch_type = (w_op == OP_BEQ) ? BR_BEQ : BR_BNE;
        w_c.ext_op      = 1'b1;
        w_rs_rd         = 1'b1;
        w_rt_rd         = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: begin
        w_c.branch      = 1'b1;
        w_c.branch_type = (w_op == OP_BLEZ) ? BR_BLEZ : BR_BGTZ;
        w_rs_rd         = 1'b1;
        w_legal         = ENABLE_EXT;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        w_c.reg_write = 1'b1;
        w_c.alu_src2  = 1'b1;
        w_c.ext_op    = (w_op == OP_ADDI) || (w_op == OP_ADDIU) || (w_op == OP_SLTI);
        w_rs_rd       = 1'b1;
      end
      OP_LUI: begin
        w_c.reg_write = 1'b1;
        w_c.alu_src2  = 1'b1;
        w_c.lu_op     = 1'b1;
      end
      OP_LW: begin
        w_c.reg_write  = 1'b1;
        w_c.mem_read   = 1'b1;
        w_c.mem_to_reg = 2'b01;
        w_c.alu_src2   = 1'b1;
        w_c.ext_op     = 1'b1;
        w_rs_rd        = 1'b1;
      end
      OP_SW: begin
        w_c.mem_write = 1'b1;
        w_c.alu_src2  = 1'b1;
        w_c.ext_op    = 1'b1;
        w_rs_rd       = 1'b1;
        w_rt_rd       = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase

    case (w_op)
      OP_RTYPE:          w_alu_lo = ALU_R;
      OP_BEQ, OP_BNE:    w_alu_lo = ALU_BEQ;
      OP_ANDI:           w_alu_lo = ALU_AND;
      OP_ORI:            w_alu_lo = ALU_OR;
      OP_XORI:           w_alu_lo = ALU_XOR;
      OP_SLTI, OP_SLTIU: w_alu_lo = ALU_SLT;
      default:           w_alu_lo = ALU_ADD;
    endcase
    w_c.alu_op = {w_op[0], w_alu_lo};
  end

  assign o_ctrl     = w_legal ? w_c : '0;
  assign o_illegal  = !w_legal;
  assign o_reads_rs = w_legal && w_rs_rd;
  assign o_reads_rt = w_legal && w_rt_rd;

endmodule

// File: rtl/decode_pipe_ctrl.sv
// Registered decode into the ID/EX control register; 1 cycle id accept -> ex_valid.
// id_ready drops on EX backpressure, load-use hazard or busy mult/div; flush discards input and register.
module decode_pipe_ctrl
  import decode_pkg::*;
#(
  parameter bit          ENABLE_EXT = 1'b1,
  parameter int unsigned MULDIV_LAT = 4,
  parameter bit          HAZARD_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_inst,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_rt,
  output logic              ex_illegal,
  output logic              muldiv_busy
);

  ctrl_t      w_ctrl;
  logic       w_illegal;
  logic       w_reads_rs;
  logic       w_reads_rt;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_mfhilo;
  logic       w_hz_load;
  logic       w_hz_md;
  logic       w_xfer;
  logic       w_md_leave;
  logic       w_unused;

  ctrl_t      r_ctrl;
  logic       r_valid;
  logic [4:0] r_rt;
  logic       r_illegal;
  logic [3:0] r_md_cnt;

  ctrl_decode #(
    .ENABLE_EXT(ENABLE_EXT)
  ) u_dec (
    .i_inst    (id_inst),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal),
    .o_reads_rs(w_reads_rs),
    .o_reads_rt(w_reads_rt)
  );

  assign w_rs     = id_inst[25:21];
  assign w_rt     = id_inst[20:16];
  assign w_unused = ^id_inst[15:6];
  assign w_mfhilo = (id_inst[31:26] == OP_RTYPE) && !w_illegal &&
                    (id_inst[5:0] == FN_MFHI || id_inst[5:0] == FN_MFLO);

  // The registered load is the only producer whose result is not yet forwardable
  assign w_hz_load = HAZARD_EN && r_valid && r_ctrl.mem_read && (r_rt != 5'd0) &&
                     ((r_rt == w_rs && w_reads_rs) || (r_rt == w_rt && w_reads_rt));
  assign w_hz_md   = (r_md_cnt != 4'd0) && (w_mfhilo || w_ctrl.mul_div);

  assign id_ready   = flush || ((!r_valid || ex_ready) && !w_hz_load && !w_hz_md);
  assign w_xfer     = id_valid && id_ready && !flush;
  assign w_md_leave = r_valid && ex_ready && r_ctrl.mul_div && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_rt      <= 5'd0;
      r_illegal <= 1'b0;
      r_md_cnt  <= 4'd0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_xfer) begin
        r_valid   <= 1'b1;
        r_ctrl    <= w_ctrl;
        r_rt      <= w_rt;
        r_illegal <= w_illegal;
      end else if (ex_ready) begin
        r_valid <= 1'b0;
      end

      // Counter keeps running through a flush: an issued mult/div still completes
      if (w_md_leave) begin
        r_md_cnt <= 4'(MULDIV_LAT);
      end else if (r_md_cnt != 4'd0) begin
        r_md_cnt <= r_md_cnt - 4'd1;
      end
    end
  end

  assign ex_valid    = r_valid;
  assign ex_ctrl     = r_ctrl;
  assign ex_rt       = r_rt;
  assign ex_illegal  = r_illegal;
  assign muldiv_busy = (r_md_cnt != 4'd0);

endmodule
